// File: rtl/chess_pkg.sv
// Shared piece codes, colour rule and move-entry FSM states.
// Imported by the move-entry stage and its bench.
package chess_pkg;

  localparam int COLOR_BIT = 3;

  localparam logic [3:0] WHITE_EMPTY  = 4'h0;
  localparam logic [3:0] WHITE_KING   = 4'h1;
  localparam logic [3:0] WHITE_QUEEN  = 4'h2;
  localparam logic [3:0] WHITE_BISHOP = 4'h3;
  localparam logic [3:0] WHITE_KNIGHT = 4'h4;
  localparam logic [3:0] WHITE_ROOK   = 4'h5;
  localparam logic [3:0] WHITE_PAWN   = 4'h6;

  localparam logic [3:0] BLACK_EMPTY  = 4'h8;
  localparam logic [3:0] BLACK_KING   = 4'h9;
  localparam logic [3:0] BLACK_QUEEN  = 4'hA;
  localparam logic [3:0] BLACK_BISHOP = 4'hB;
  localparam logic [3:0] BLACK_KNIGHT = 4'hC;
  localparam logic [3:0] BLACK_ROOK   = 4'hD;
  localparam logic [3:0] BLACK_PAWN   = 4'hE;

  typedef enum logic [3:0] {
    IDLE_SRC  = 4'd0,
    READ_SRC  = 4'd1,
    CHECK_SRC = 4'd2,
    WAIT_DST  = 4'd3,
    READ_DST  = 4'd4,
    CHECK_DST = 4'd5,
    EVAL      = 4'd6,
    WRITE_DST = 4'd7,
    WRITE_SRC = 4'd8,
    DONE      = 4'd9
  } state_t;

  function automatic logic is_empty(input logic [3:0] p);
    return p[2:0] == 3'b000;
  endfunction

endpackage

// File: rtl/move_controller.sv
// Move-entry stage: latches source/target squares and pieces,
// waits for the legality checkers, then commits the move to board RAM.
module move_controller
  import chess_pkg::*;
#(
  parameter int unsigned EVAL_CYCLES = 1,
  parameter logic [3:0]  EMPTY_CODE  = 4'b0000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] cursorPosition,
  input  logic       selectPress,
  input  logic       cancelPress,
  input  logic [3:0] boardReadData,
  input  logic       allowMove,
  output logic [5:0] boardReadAddr,
  output logic       boardWriteEn,
  output logic [5:0] boardWriteAddr,
  output logic [3:0] boardWriteData,
  output logic [5:0] currentPosition,
  output logic [5:0] targetPosition,
  output logic [3:0] currentPiece,
  output logic [3:0] targetPiece,
  output logic       turn,
  output logic       moveDone,
  output logic       moveRejected
);

  localparam logic [2:0] LAST = 3'(EVAL_CYCLES - 1);

  state_t     state, state_n;
  logic [2:0] cnt, cnt_n;
  logic [5:0] raddr_n, cur_n, tgt_n;
  logic [3:0] cpc_n, tpc_n;
  logic       turn_n;
  logic       own;

  // State and latched move registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE_SRC;
      cnt             <= '0;
      boardReadAddr   <= '0;
      currentPosition <= '0;
      targetPosition  <= '0;
      currentPiece    <= '0;
      targetPiece     <= '0;
      turn            <= 1'b0;
    end else begin
      state           <= state_n;
      cnt             <= cnt_n;
      boardReadAddr   <= raddr_n;
      currentPosition <= cur_n;
      targetPosition  <= tgt_n;
      currentPiece    <= cpc_n;
      targetPiece     <= tpc_n;
      turn            <= turn_n;
    end
  end

  // Next-state, register updates and strobes
  always_comb begin
    state_n        = state;
    cnt_n          = cnt;
    raddr_n        = boardReadAddr;
    cur_n          = currentPosition;
    tgt_n          = targetPosition;
    cpc_n          = currentPiece;
    tpc_n          = targetPiece;
    turn_n         = turn;
    boardWriteEn   = 1'b0;
    boardWriteAddr = '0;
    boardWriteData = '0;
    moveDone       = 1'b0;
    moveRejected   = 1'b0;
    own = !is_empty(boardReadData) &&
          (boardReadData[COLOR_BIT] == turn);
    unique case (state)
      IDLE_SRC: begin
        if (selectPress) begin
          raddr_n = cursorPosition;
          cur_n   = cursorPosition;
          state_n = READ_SRC;
        end
      end
      READ_SRC: state_n = CHECK_SRC;
      CHECK_SRC: begin
        if (own) begin
          cpc_n   = boardReadData;
          state_n = WAIT_DST;
        end else begin
          moveRejected = 1'b1;
          state_n      = IDLE_SRC;
        end
      end
      WAIT_DST: begin
        if (cancelPress) begin
          state_n = IDLE_SRC;
        end else if (selectPress) begin
          raddr_n = cursorPosition;
          tgt_n   = cursorPosition;
          state_n = READ_DST;
        end
      end
      READ_DST: state_n = CHECK_DST;
      CHECK_DST: begin
        if (targetPosition == currentPosition) begin
          state_n = IDLE_SRC;
        end else if (own) begin
          cur_n   = targetPosition;
          cpc_n   = boardReadData;
          state_n = WAIT_DST;
        end else begin
          tpc_n   = boardReadData;
          cnt_n   = '0;
          state_n = EVAL;
        end
      end
      EVAL: begin
        if (cnt == LAST) begin
          cnt_n = '0;
          if (allowMove) begin
            state_n = WRITE_DST;
          end else begin
            moveRejected = 1'b1;
            state_n      = WAIT_DST;
          end
        end else begin
          cnt_n = cnt + 3'd1;
        end
      end
      WRITE_DST: begin
        boardWriteEn   = 1'b1;
        boardWriteAddr = targetPosition;
        boardWriteData = currentPiece;
        state_n        = WRITE_SRC;
      end
      WRITE_SRC: begin
        boardWriteEn   = 1'b1;
        boardWriteAddr = currentPosition;
        boardWriteData = EMPTY_CODE;
        state_n        = DONE;
      end
      DONE: begin
        moveDone = 1'b1;
        turn_n   = ~turn;
        state_n  = IDLE_SRC;
      end
      default: state_n = IDLE_SRC;
    endcase
  end

endmodule

// File: tb/tb_move_controller.sv
// Bench for move_controller: transaction-level board/selection
// model producing per-cycle expected outputs, plus directed pins.
module tb_move_controller;
  import chess_pkg::*;

  localparam int EC = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] cursorPosition;
  logic       selectPress, cancelPress;
  logic [3:0] boardReadData;
  logic       allowMove;
  logic [5:0] boardReadAddr, boardWriteAddr;
  logic       boardWriteEn;
  logic [3:0] boardWriteData;
  logic [5:0] currentPosition, targetPosition;
  logic [3:0] currentPiece, targetPiece;
  logic       turn, moveDone, moveRejected;

  always #5 clk = ~clk;

  move_controller #(.EVAL_CYCLES(EC), .EMPTY_CODE(4'b0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .cursorPosition(cursorPosition),
    .selectPress(selectPress), .cancelPress(cancelPress),
    .boardReadData(boardReadData), .allowMove(allowMove),
    .boardReadAddr(boardReadAddr), .boardWriteEn(boardWriteEn),
    .boardWriteAddr(boardWriteAddr), .boardWriteData(boardWriteData),
    .currentPosition(currentPosition), .targetPosition(targetPosition),
    .currentPiece(currentPiece), .targetPiece(targetPiece),
    .turn(turn), .moveDone(moveDone), .moveRejected(moveRejected)
  );

  // board RAM, synchronous read with one cycle latency
  logic [3:0] ram [64];
  always @(posedge clk) begin
    boardReadData <= ram[boardReadAddr];
    if (boardWriteEn) ram[boardWriteAddr] <= boardWriteData;
  end

  typedef struct packed {
    logic [5:0] raddr;
    logic [5:0] cur;
    logic [5:0] tgt;
    logic [3:0] cpc;
    logic [3:0] tpc;
    logic       turn;
    logic       we;
    logic [5:0] waddr;
    logic [3:0] wdata;
    logic       done;
    logic       rej;
  } rec_t;

  rec_t act, ex;
  logic ex_valid = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always_comb begin
    act.raddr = boardReadAddr;
    act.cur   = currentPosition;
    act.tgt   = targetPosition;
    act.cpc   = currentPiece;
    act.tpc   = targetPiece;
    act.turn  = turn;
    act.we    = boardWriteEn;
    act.waddr = boardWriteAddr;
    act.wdata = boardWriteData;
    act.done  = moveDone;
    act.rej   = moveRejected;
  end

  // model state
  logic [3:0] board [64];
  logic [5:0] m_raddr, m_cur, m_tgt;
  logic [3:0] m_cpc, m_tpc;
  logic       m_turn, m_sel;

  function automatic string fmt(input rec_t r);
    return $sformatf(
      "ra=%0d cur=%0d tgt=%0d cp=%h tp=%h turn=%0d we=%0d wa=%0d wd=%h done=%0d rej=%0d",
      r.raddr, r.cur, r.tgt, r.cpc, r.tpc, r.turn, r.we,
      r.waddr, r.wdata, r.done, r.rej);
  endfunction

  // per-cycle comparison against the model expectation
  always @(negedge clk) begin
    if (ex_valid) begin
      checks++;
      if (act !== ex) begin
        errors++;
        $display("FAIL cycle @%0t got {%s} required {%s}",
                 $time, fmt(act), fmt(ex));
      end
    end
  end

  task automatic chk(input string n, input logic [63:0] a,
                     input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h required %0h", n, a, e);
    end
  endtask

  function automatic rec_t steady();
    rec_t r;
    r = '0;
    r.raddr = m_raddr;
    r.cur   = m_cur;
    r.tgt   = m_tgt;
    r.cpc   = m_cpc;
    r.tpc   = m_tpc;
    r.turn  = m_turn;
    return r;
  endfunction

  function automatic logic own_p(input logic [3:0] p);
    return (p[2:0] != 3'b000) && (p[3] == m_turn);
  endfunction

  function automatic logic [3:0] back_rank(input int f);
    case (f)
      0, 7:    return WHITE_ROOK;
      1, 6:    return WHITE_KNIGHT;
      2, 5:    return WHITE_BISHOP;
      3:       return WHITE_QUEEN;
      default: return WHITE_KING;
    endcase
  endfunction

  task automatic init_board();
    for (int i = 0; i < 64; i++) board[i] = WHITE_EMPTY;
    for (int f = 0; f < 8; f++) begin
      board[f]      = back_rank(f) | 4'h8;
      board[8 + f]  = BLACK_PAWN;
      board[48 + f] = WHITE_PAWN;
      board[56 + f] = back_rank(f);
    end
    for (int i = 0; i < 64; i++) ram[i] = board[i];
  endtask

  task automatic model_reset();
    m_raddr = '0; m_cur = '0; m_tgt = '0;
    m_cpc = '0; m_tpc = '0; m_turn = 1'b0; m_sel = 1'b0;
  endtask

  // one clock cycle: expectation and inputs for the current cycle
  task automatic cyc(input rec_t e, input logic s, input logic c,
                     input logic [5:0] pos, input logic am);
    ex = e;
    ex_valid = 1'b1;
    selectPress = s;
    cancelPress = c;
    cursorPosition = pos;
    allowMove = am;
    @(posedge clk);
    #1;
  endtask

  // a cycle where the DUT must ignore select/cancel
  task automatic busy(input rec_t e);
    cyc(e, ($urandom % 4) == 0, ($urandom % 4) == 0,
        6'($urandom), 1'($urandom));
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++)
      cyc(steady(), 1'b0, 1'b0, 6'($urandom), 1'($urandom));
  endtask

  task automatic do_cancel();
    cyc(steady(), 1'b0, 1'b1, 6'($urandom), 1'($urandom));
    m_sel = 1'b0;
    gap(1);
  endtask

  task automatic do_select(input logic [5:0] sq, input logic legal,
                           input logic with_cancel,
                           input logic rst_mid);
    rec_t e;
    logic [3:0] p;
    cyc(steady(), 1'b1, with_cancel, sq, 1'($urandom));
    if (m_sel && with_cancel) begin
      m_sel = 1'b0;
      gap(1);
      return;
    end
    m_raddr = sq;
    if (!m_sel) begin
      m_cur = sq;
      busy(steady());
      p = board[sq];
      e = steady();
      e.rej = !own_p(p);
      busy(e);
      if (own_p(p)) begin
        m_cpc = p;
        m_sel = 1'b1;
      end
      gap(1 + ($urandom % 2));
      return;
    end
    m_tgt = sq;
    busy(steady());
    p = board[sq];
    busy(steady());
    if (sq == m_cur) begin
      m_sel = 1'b0;
      gap(1);
      return;
    end
    if (own_p(p)) begin
      m_cur = sq;
      m_cpc = p;
      gap(1);
      return;
    end
    m_tpc = p;
    for (int i = 0; i < EC; i++) begin
      e = steady();
      e.rej = (i == EC - 1) && !legal;
      cyc(e, ($urandom % 4) == 0, ($urandom % 4) == 0,
          6'($urandom), legal);
    end
    if (!legal) begin
      gap(1);
      return;
    end
    e = steady();
    e.we = 1'b1; e.waddr = m_tgt; e.wdata = m_cpc;
    busy(e);
    board[m_tgt] = m_cpc;
    if (rst_mid) begin
      ex_valid = 1'b0;
      selectPress = 1'b0;
      cancelPress = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_outputs", 64'(act), 64'd0);
      chk("async_rst_turn", 64'(turn), 64'd0);
      chk("async_rst_we", 64'(boardWriteEn), 64'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      return;
    end
    e = steady();
    e.we = 1'b1; e.waddr = m_cur; e.wdata = 4'h0;
    busy(e);
    board[m_cur] = 4'h0;
    e = steady();
    e.done = 1'b1;
    busy(e);
    m_turn = ~m_turn;
    m_sel = 1'b0;
    gap(1 + ($urandom % 2));
  endtask

  initial begin
    logic [5:0] sq;
    rst_n = 1'b0;
    selectPress = 1'b0;
    cancelPress = 1'b0;
    cursorPosition = '0;
    allowMove = 1'b0;
    init_board();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_outputs", 64'(act), 64'd0);
    chk("rst_turn", 64'(turn), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // wrong colour source
    do_select(6'd12, 1'b0, 1'b0, 1'b0);
    chk("wrongcol_cpc", 64'(currentPiece), 64'd0);
    // illegal distance keeps source
    do_select(6'd52, 1'b0, 1'b0, 1'b0);
    do_select(6'd43, 1'b0, 1'b0, 1'b0);
    chk("illegal_cur", 64'(currentPosition), 64'd52);
    chk("illegal_ram43", 64'(ram[43]), 64'd0);
    // reselect then deselect
    do_select(6'd51, 1'b0, 1'b0, 1'b0);
    chk("reselect_cur", 64'(currentPosition), 64'd51);
    chk("reselect_cpc", 64'(currentPiece), 64'd6);
    do_select(6'd51, 1'b0, 1'b0, 1'b0);
    // cancel beats select
    do_select(6'd52, 1'b0, 1'b0, 1'b0);
    do_select(6'd44, 1'b1, 1'b1, 1'b0);
    chk("cancel_raddr", 64'(boardReadAddr), 64'd52);
    // legal pawn push
    do_select(6'd52, 1'b0, 1'b0, 1'b0);
    do_select(6'd36, 1'b1, 1'b0, 1'b0);
    chk("legal_ram36", 64'(ram[36]), 64'd6);
    chk("legal_ram52", 64'(ram[52]), 64'd0);
    chk("legal_turn", 64'(turn), 64'd1);
    chk("legal_model_turn", 64'(m_turn), 64'd1);
    // reset during WRITE_SRC leaves half-written board
    do_select(6'd12, 1'b0, 1'b0, 1'b0);
    do_select(6'd28, 1'b1, 1'b0, 1'b1);
    chk("halfmove_ram28", 64'(ram[28]), 64'hE);
    chk("halfmove_ram12", 64'(ram[12]), 64'hE);

    // randomized play
    for (int n = 0; n < 250; n++) begin
      int r;
      r = $urandom % 10;
      if (r == 0) begin
        do_cancel();
      end else begin
        sq = 6'($urandom);
        if (!m_sel && ($urandom % 5) != 0) begin
          for (int k = 0; k < 64; k++) begin
            if (own_p(board[sq])) break;
            sq = 6'($urandom);
          end
        end
        do_select(sq, ($urandom % 3) != 0, r == 1, 1'b0);
      end
    end

    ex_valid = 1'b0;
    for (int i = 0; i < 64; i++)
      chk($sformatf("final_ram%0d", i), 64'(ram[i]), 64'(board[i]));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
